// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a framed byte stream
// (header, 3-byte little-endian instructions, XOR checksum) and holds
// the core until a complete image has been written and verified.
module imem_loader #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 20
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  input  logic                   reload,
  output logic                   imem_we,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic                   core_hold,
  output logic                   done,
  output logic                   error,
  output logic [ADDR_WIDTH:0]    load_count
);

  // Number of meaningful bits carried by the third byte of an instruction.
  localparam int B2_BITS = INSTR_WIDTH - 16;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_B0    = 3'd1,
    ST_B1    = 3'd2,
    ST_B2    = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

  // Running XOR checksum step.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // The top byte of an instruction may only use the bits that fit the word;
  // anything set above them marks a malformed frame.
  function automatic logic b2_format_ok(input logic [7:0] b);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ok = ok & ~(b[i] & (i >= B2_BITS));
    end
    return ok;
  endfunction

  state_t                 state_r;
  logic [7:0]             b0_r;
  logic [7:0]             b1_r;
  logic [7:0]             csum_r;
  logic [8:0]             remaining_r;
  logic [ADDR_WIDTH-1:0]  addr_r;
  logic                   in_ready_s;
  logic                   accept_s;
  logic [INSTR_WIDTH-1:0] word_s;

  // Ready is a pure decode of the current state, never of in_valid.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      ST_HDR, ST_B0, ST_B1, ST_B2, ST_CSUM: in_ready_s = 1'b1;
      ST_DONE, ST_ERROR:                    in_ready_s = 1'b0;
      default:                              in_ready_s = 1'b0;
    endcase
  end

  assign in_ready = in_ready_s;
  assign accept_s = in_valid & in_ready_s;
  assign word_s   = INSTR_WIDTH'({in_data, b1_r, b0_r});

  // Loader FSM: frame parsing, checksum, memory write pulse and status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_HDR;
      b0_r        <= 8'h00;
      b1_r        <= 8'h00;
      csum_r      <= 8'h00;
      remaining_r <= 9'd0;
      addr_r      <= {ADDR_WIDTH{1'b0}};
      imem_we     <= 1'b0;
      imem_addr   <= {ADDR_WIDTH{1'b0}};
      imem_wdata  <= {INSTR_WIDTH{1'b0}};
      core_hold   <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
      load_count  <= {(ADDR_WIDTH+1){1'b0}};
    end else begin
      imem_we <= 1'b0;
      case (state_r)
        ST_HDR: begin
          if (accept_s) begin
            remaining_r <= {1'b0, in_data} + 9'd1;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            csum_r      <= in_data;
            load_count  <= {(ADDR_WIDTH+1){1'b0}};
            state_r     <= ST_B0;
          end
        end
        ST_B0: begin
          if (accept_s) begin
            b0_r    <= in_data;
            csum_r  <= csum_step(csum_r, in_data);
            state_r <= ST_B1;
          end
        end
        ST_B1: begin
          if (accept_s) begin
            b1_r    <= in_data;
            csum_r  <= csum_step(csum_r, in_data);
            state_r <= ST_B2;
          end
        end
        ST_B2: begin
          if (accept_s) begin
            if (!b2_format_ok(in_data)) begin
              // Malformed top byte: abandon the frame without writing.
              state_r <= ST_ERROR;
              error   <= 1'b1;
              done    <= 1'b0;
            end else begin
              csum_r      <= csum_step(csum_r, in_data);
              imem_we     <= 1'b1;
              imem_addr   <= addr_r;
              imem_wdata  <= word_s;
              addr_r      <= addr_r + ADDR_ONE;
              remaining_r <= remaining_r - 9'd1;
              load_count  <= load_count + CNT_ONE;
              state_r     <= (remaining_r == 9'd1) ? ST_CSUM : ST_B0;
            end
          end
        end
        ST_CSUM: begin
          if (accept_s) begin
            if (in_data == csum_r) begin
              state_r   <= ST_DONE;
              done      <= 1'b1;
              error     <= 1'b0;
              core_hold <= 1'b0;
            end else begin
              state_r <= ST_ERROR;
              error   <= 1'b1;
              done    <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          if (reload) begin
            state_r   <= ST_HDR;
            done      <= 1'b0;
            core_hold <= 1'b1;
          end
        end
        ST_ERROR: begin
          // The core stays held here; partial contents are never executed.
          if (reload) begin
            state_r <= ST_HDR;
            error   <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_HDR;
          core_hold <= 1'b1;
          done      <= 1'b0;
          error     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: single/full images, checksum and format
// errors, backpressure gaps and reset in the middle of a load.
`timescale 1ns/1ps
module tb_imem_loader;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        reload;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [19:0] imem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;
  logic [8:0]  load_count;

  int vec_cnt = 0;
  int miscompare_cnt = 0;

  int          wr_cnt = 0;
  logic [7:0]  wr_addr [0:1023];
  logic [19:0] wr_data [0:1023];
  int          base;

  imem_loader #(.ADDR_WIDTH(8), .INSTR_WIDTH(20)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .done       (done),
    .error      (error),
    .load_count (load_count)
  );

  // Free-running clock, 10 ns period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Log every cycle imem_we is seen high, so a stretched pulse shows as extra writes.
  always @(posedge clock) begin
    if (imem_we === 1'b1) begin
      if (wr_cnt < 1024) begin
        wr_addr[wr_cnt] <= imem_addr;
        wr_data[wr_cnt] <= imem_wdata;
      end
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte for exactly one handshake cycle after 'gap' idle cycles.
  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clock);
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    @(negedge clock);
    reload = 1'b1;
    @(posedge clock);
    #1;
    reload = 1'b0;
  endtask

  task automatic check_reset_values(input string pfx);
    check_val({pfx, "_in_ready"},   in_ready,   1);
    check_val({pfx, "_imem_we"},    imem_we,    0);
    check_val({pfx, "_imem_addr"},  imem_addr,  0);
    check_val({pfx, "_imem_wdata"}, imem_wdata, 0);
    check_val({pfx, "_core_hold"},  core_hold,  1);
    check_val({pfx, "_done"},       done,       0);
    check_val({pfx, "_error"},      error,      0);
    check_val({pfx, "_load_count"}, load_count, 0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_values("rst");
    @(negedge clock);
    reset = 1'b0;

    // Single instruction: 0x51234 at addr 0, checksum 0x23.
    base = wr_cnt;
    send(8'h00, 0);
    send(8'h34, 0);
    send(8'h12, 0);
    send(8'h05, 0);
    check_val("single_we",    imem_we,    1);
    check_val("single_addr",  imem_addr,  8'h00);
    check_val("single_wdata", imem_wdata, 20'h51234);
    check_val("single_cnt",   load_count, 1);
    check_val("single_hold_pre", core_hold, 1);
    send(8'h23, 0);
    check_val("single_we_low", imem_we,   0);
    check_val("single_done",  done,       1);
    check_val("single_hold",  core_hold,  0);
    check_val("single_err",   error,      0);
    check_val("single_rdy",   in_ready,   0);
    check_val("single_nwr",   wr_cnt - base, 1);
    pulse_reload();
    check_val("reload_rdy",   in_ready,   1);
    check_val("reload_done",  done,       0);
    check_val("reload_hold",  core_hold,  1);

    // Checksum mismatch.
    send(8'h00, 0);
    send(8'h34, 0);
    send(8'h12, 0);
    send(8'h05, 0);
    send(8'h24, 0);
    check_val("csum_err",  error,     1);
    check_val("csum_done", done,      0);
    check_val("csum_hold", core_hold, 1);
    check_val("csum_rdy",  in_ready,  0);
    pulse_reload();
    check_val("csum_rl_err", error,    0);
    check_val("csum_rl_rdy", in_ready, 1);
    check_val("csum_rl_hold", core_hold, 1);

    // Format error on first instruction's top byte.
    base = wr_cnt;
    send(8'h01, 0);
    send(8'h34, 0);
    send(8'h12, 0);
    send(8'h15, 0);
    check_val("fmt_err",  error,      1);
    check_val("fmt_we",   imem_we,    0);
    check_val("fmt_cnt",  load_count, 0);
    check_val("fmt_rdy",  in_ready,   0);
    check_val("fmt_done", done,       0);
    @(posedge clock);
    #1;
    check_val("fmt_nwr",  wr_cnt - base, 0);
    pulse_reload();

    // Backpressure: random idle gaps between bytes.
    base = wr_cnt;
    send(8'h00, $urandom_range(0, 5));
    send(8'h34, $urandom_range(0, 5));
    send(8'h12, $urandom_range(0, 5));
    send(8'h05, $urandom_range(0, 5));
    send(8'h23, $urandom_range(0, 5));
    @(posedge clock);
    #1;
    check_val("bp_nwr",   wr_cnt - base, 1);
    check_val("bp_addr",  wr_addr[base], 8'h00);
    check_val("bp_wdata", wr_data[base], 20'h51234);
    check_val("bp_done",  done,       1);
    check_val("bp_hold",  core_hold,  0);
    check_val("bp_cnt",   load_count, 1);
    pulse_reload();

    // Full image: 256 instructions, instruction i = i; XOR of 0..255 is 0, so checksum = 0xFF.
    base = wr_cnt;
    send(8'hFF, 0);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] lo;
      lo = i[7:0];
      send(lo, 0);
      send(8'h00, 0);
      send(8'h00, 0);
    end
    check_val("full_last_addr", imem_addr, 8'hFF);
    send(8'hFF, 0);
    @(posedge clock);
    #1;
    check_val("full_nwr",  wr_cnt - base, 256);
    check_val("full_cnt",  load_count, 256);
    check_val("full_done", done, 1);
    check_val("full_err",  error, 0);
    for (int i = 0; i < 256; i++) begin
      check_val($sformatf("full_addr%0d", i), wr_addr[base + i], i);
      check_val($sformatf("full_data%0d", i), wr_data[base + i], i);
    end
    pulse_reload();

    // Reset asserted on the B2 handshake edge: write must be cancelled.
    base = wr_cnt;
    send(8'h00, 0);
    send(8'h34, 0);
    send(8'h12, 0);
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = 8'h05;
    reset    = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    check_reset_values("mid");
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_val("mid_nwr", wr_cnt - base, 0);

    // Good frame after the aborted one: 0xEABCD, checksum CD^AB^0E = 0x68.
    send(8'h00, 0);
    send(8'hCD, 0);
    send(8'hAB, 0);
    send(8'h0E, 0);
    send(8'h68, 0);
    @(posedge clock);
    #1;
    check_val("post_nwr",   wr_cnt - base, 1);
    check_val("post_addr",  wr_addr[base], 8'h00);
    check_val("post_wdata", wr_data[base], 20'hEABCD);
    check_val("post_done",  done, 1);
    check_val("post_hold",  core_hold, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule
